// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable registered or fall-through read port.
module param_sync_fifo #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int AF_LEVEL = (2**ADDR_W) - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wrt_data,
  input  logic              wrt_en,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr_r, rptr_r, count_r, count_s;
  logic              full_r, empty_r, af_r, ae_r;
  logic              overflow_r, underflow_r;
  logic              wa_s, ra_s;

  // Acceptance is judged on registered state only; next count feeds the registered flags.
  always_comb begin
    wa_s    = wrt_en & ~full_r;
    ra_s    = rd_en & ~empty_r;
    count_s = count_r;
    case ({wa_s, ra_s})
      2'b10:   count_s = count_r + ONE_C;
      2'b01:   count_s = count_r - ONE_C;
      default: count_s = count_r;
    endcase
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
    end else begin
      if (wa_s) wptr_r <= wptr_r + ONE_C;
      if (ra_s) rptr_r <= rptr_r + ONE_C;
      count_r <= count_s;
      full_r  <= (count_s == DEPTH_C);
      empty_r <= (count_s == '0);
      af_r    <= (count_s >= AF_C);
      ae_r    <= (count_s <= AE_C);
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wrt_en & full_r)  overflow_r <= 1'b1;
      else if (err_clr)     overflow_r <= 1'b0;
      if (rd_en & empty_r)  underflow_r <= 1'b1;
      else if (err_clr)     underflow_r <= 1'b0;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wa_s) mem[wptr_r[ADDR_W-1:0]] <= wrt_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem[rptr_r[ADDR_W-1:0]];
      assign rd_valid = ~empty_r;
    end else begin : g_reg
      logic [DATA_W-1:0] rd_data_r;
      logic              rd_valid_r;

      // Registered read port: one-cycle valid pulse per accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_r  <= '0;
          rd_valid_r <= 1'b0;
        end else begin
          rd_valid_r <= ra_s;
          if (ra_s) rd_data_r <= mem[rptr_r[ADDR_W-1:0]];
        end
      end

      assign rd_data  = rd_data_r;
      assign rd_valid = rd_valid_r;
    end
  endgenerate

  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a registered-read instance and an FWFT instance.
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wrt_data, wrt_data1;
  logic        wrt_en, rd_en, err_clr, wrt_en1, rd_en1;
  logic [15:0] rd_data, rd_data1;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic        rd_valid1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [6:0]  count, count1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(16), .ADDR_W(6), .AF_LEVEL(60), .AE_LEVEL(4), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_data(wrt_data), .wrt_en(wrt_en), .rd_en(rd_en),
    .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  param_sync_fifo #(.DATA_W(16), .ADDR_W(6), .AF_LEVEL(60), .AE_LEVEL(4), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wrt_data(wrt_data1), .wrt_en(wrt_en1), .rd_en(rd_en1),
    .err_clr(err_clr), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wrt_data = '0; wrt_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    wrt_data1 = '0; wrt_en1 = 1'b0; rd_en1 = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_fwft_valid", rd_valid1, 0);

    // FWFT: word appears without rd_en, then pops
    wrt_data1 = 16'hA5A5; wrt_en1 = 1'b1;
    tick();
    wrt_en1 = 1'b0;
    chk("fwft_data", rd_data1, 16'hA5A5);
    chk("fwft_valid", rd_valid1, 1);
    chk("fwft_empty0", empty1, 0);
    tick();
    chk("fwft_hold", rd_data1, 16'hA5A5);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    chk("fwft_empty1", empty1, 1);
    chk("fwft_valid0", rd_valid1, 0);
    wrt_en1 = 1'b1; wrt_data1 = 16'h1111;
    tick();
    wrt_data1 = 16'h2222;
    tick();
    wrt_en1 = 1'b0;
    chk("fwft_head1", rd_data1, 16'h1111);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    chk("fwft_head2", rd_data1, 16'h2222);
    chk("fwft_cnt", count1, 1);

    // Fill 0x0001..0x0040
    wrt_en = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      wrt_data = 16'(i);
      tick();
      chk("fill_count", count, 32'(i));
      chk("fill_af", almost_full, (i >= 60) ? 32'd1 : 32'd0);
      chk("fill_ae", almost_empty, (i <= 4) ? 32'd1 : 32'd0);
      chk("fill_full", full, (i == 64) ? 32'd1 : 32'd0);
    end
    wrt_data = 16'hDEAD;
    tick();
    wrt_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 64);

    // Drain in order
    rd_en = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk("drain_data", rd_data, 32'(i));
      chk("drain_valid", rd_valid, 1);
      chk("drain_count", count, 32'(64 - i));
    end
    rd_en = 1'b0;
    tick();
    chk("drain_pulse_end", rd_valid, 0);
    chk("drain_hold", rd_data, 16'h0040);
    chk("drain_empty", empty, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_set", underflow, 1);
    chk("udf_novalid", rd_valid, 0);
    chk("udf_count", count, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);

    // Steady state at count=10 across pointer wrap
    wrt_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wrt_data = 16'(16'h0100 + k);
      tick();
    end
    chk("ss_pre", count, 10);
    rd_en = 1'b1;
    for (int j = 0; j < 200; j++) begin
      wrt_data = 16'(16'h010A + j);
      tick();
      chk("ss_count", count, 10);
      chk("ss_data", rd_data, 32'(16'h0100 + j));
      chk("ss_valid", rd_valid, 1);
    end
    rd_en = 1'b0;

    // Full with both requests: read only
    for (int k = 0; k < 54; k++) begin
      wrt_data = 16'h7777;
      tick();
    end
    chk("full_pre", full, 1);
    rd_en = 1'b1;
    tick();
    wrt_en = 1'b0; rd_en = 1'b0;
    chk("fb_count", count, 63);
    chk("fb_ovf", overflow, 1);
    chk("fb_data", rd_data, 16'h01C8);
    chk("fb_full", full, 0);

    // Empty with both requests: write only
    rd_en = 1'b1;
    for (int k = 0; k < 63; k++) tick();
    rd_en = 1'b0;
    chk("eb_pre", empty, 1);
    wrt_en = 1'b1; rd_en = 1'b1; wrt_data = 16'h4242;
    tick();
    wrt_en = 1'b0; rd_en = 1'b0;
    chk("eb_count", count, 1);
    chk("eb_udf", underflow, 1);
    chk("eb_novalid", rd_valid, 0);

    // Asynchronous reset mid-stream at count=37
    wrt_en = 1'b1;
    for (int k = 0; k < 36; k++) tick();
    wrt_en = 1'b0;
    chk("ar_pre", count, 37);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_ovf", overflow, 0);
    chk("ar_udf", underflow, 0);
    chk("ar_ae", almost_empty, 1);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_post", count, 0);

    // err_clr together with a new overflow keeps the flag
    wrt_en = 1'b1;
    for (int k = 0; k < 64; k++) tick();
    chk("ec_full", full, 1);
    tick();
    chk("ec_ovf", overflow, 1);
    err_clr = 1'b1;
    tick();
    chk("ec_coincide", overflow, 1);
    wrt_en = 1'b0;
    tick();
    err_clr = 1'b0;
    chk("ec_cleared", overflow, 0);
    chk("ec_count", count, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
